// File: rtl/emu_sched_pkg.sv
// Shared types and helpers for the emulator timestep scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: scheduler FSM state enum, default widths, dt_t, onehot_lowest().
package emu_sched_pkg;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DT_WIDTH   = 32;
  localparam int DEF_TIME_WIDTH = 64;
  localparam int DEF_CNT_WIDTH  = 32;
  localparam int MAX_REQ        = 16;

  typedef logic [DEF_DT_WIDTH-1:0] dt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Keep only the lowest set bit of a requester mask.
  function automatic logic [MAX_REQ-1:0] onehot_lowest(input logic [MAX_REQ-1:0] v);
    return v & (~v + MAX_REQ'(1));
  endfunction

endpackage

// File: rtl/emu_dt_min_tree.sv
// Combinational minimum-finder over N_REQ valid timestep proposals.
// Latency: 0 cycles (pure combinational, log2(N_REQ) compare levels).
// Backpressure: none; result follows inputs every cycle.
//
// Ports: dt_req/dt_req_vld  packed proposals and valids (requester i at [i*DT_WIDTH +: DT_WIDTH])
//        min_dt/winner_idx  smallest valid proposal and its index (ties -> lower index)
//        any_vld            at least one proposal valid
module emu_dt_min_tree
  import emu_sched_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int DT_WIDTH = DEF_DT_WIDTH,
  parameter int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  input  logic [N_REQ-1:0]          dt_req_vld,
  output logic [DT_WIDTH-1:0]       min_dt,
  output logic [IDX_W-1:0]          winner_idx,
  output logic                      any_vld
);

  // Leaves are padded to a power of two; pad leaves are never valid.
  localparam int LV = (N_REQ > 1) ? $clog2(N_REQ) : 0;
  localparam int P  = 1 << LV;

  genvar l, j;
  generate
    for (l = 0; l <= LV; l++) begin : g_lvl
      localparam int W = P >> l;
      logic [W-1:0][DT_WIDTH-1:0] val;
      logic [W-1:0][IDX_W-1:0]    idx;
      logic [W-1:0]               vld;

      for (j = 0; j < W; j++) begin : g_node
        if (l == 0) begin : g_leaf
          if (j < N_REQ) begin : g_real
            assign val[j] = dt_req[j*DT_WIDTH +: DT_WIDTH];
            assign idx[j] = IDX_W'(j);
            assign vld[j] = dt_req_vld[j];
          end else begin : g_pad
            assign val[j] = '0;
            assign idx[j] = '0;
            assign vld[j] = 1'b0;
          end
        end else begin : g_cmp
          // Right operand wins only if strictly smaller, so ties keep the
          // lower-index (left) requester.
          logic take_r;
          assign take_r = g_lvl[l-1].vld[2*j+1] &&
                          (!g_lvl[l-1].vld[2*j] ||
                           (g_lvl[l-1].val[2*j+1] < g_lvl[l-1].val[2*j]));
          assign val[j] = take_r ? g_lvl[l-1].val[2*j+1] : g_lvl[l-1].val[2*j];
          assign idx[j] = take_r ? g_lvl[l-1].idx[2*j+1] : g_lvl[l-1].idx[2*j];
          assign vld[j] = g_lvl[l-1].vld[2*j] | g_lvl[l-1].vld[2*j+1];
        end
      end
    end
  endgenerate

  assign min_dt     = g_lvl[LV].val[0];
  assign winner_idx = g_lvl[LV].idx[0];
  assign any_vld    = g_lvl[LV].vld[0];

endmodule

// File: rtl/emu_dt_scheduler.sv
// Global emulator timestep scheduler: grants min(valid dt_req, cfg_dt_max) each RUN cycle.
// Latency: 1 cycle from RUN-cycle sample to emu_step_en/emu_dt/emu_time; done 1 cycle after last step.
// Backpressure: none; requesters are sampled every RUN cycle, no flow control.
//
// Ports: cfg_dt_max cap; cmd_start/cmd_steps/cmd_halt host run control;
//        dt_req/dt_req_vld proposals; emu_dt/emu_step_en/emu_limiter/emu_time grant outputs;
//        busy (in RUN), done (end-of-run pulse), time_ovf (sticky accumulator wrap).
module emu_dt_scheduler
  import emu_sched_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DT_WIDTH   = DEF_DT_WIDTH,
  parameter int TIME_WIDTH = DEF_TIME_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DT_WIDTH-1:0]       cfg_dt_max,
  input  logic                      cmd_start,
  input  logic [CNT_WIDTH-1:0]      cmd_steps,
  input  logic                      cmd_halt,
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  input  logic [N_REQ-1:0]          dt_req_vld,
  output logic [DT_WIDTH-1:0]       emu_dt,
  output logic                      emu_step_en,
  output logic [N_REQ-1:0]          emu_limiter,
  output logic [TIME_WIDTH-1:0]     emu_time,
  output logic                      busy,
  output logic                      done,
  output logic                      time_ovf
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Wide enough for both operands plus a carry, even if DT_WIDTH > TIME_WIDTH.
  localparam int SW    = ((TIME_WIDTH > DT_WIDTH) ? TIME_WIDTH : DT_WIDTH) + 1;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] budget;

  logic [DT_WIDTH-1:0]  min_dt;
  logic [IDX_W-1:0]     win_idx;
  logic                 any_vld;
  logic                 use_cap;
  logic [DT_WIDTH-1:0]  cand;
  logic [N_REQ-1:0]     cand_lim;
  logic [SW-1:0]        time_sum;
  logic                 time_carry;
  logic                 step_fire;
  logic                 start_ok;

  emu_dt_min_tree #(
    .N_REQ    (N_REQ),
    .DT_WIDTH (DT_WIDTH),
    .IDX_W    (IDX_W)
  ) u_min_tree (
    .dt_req     (dt_req),
    .dt_req_vld (dt_req_vld),
    .min_dt     (min_dt),
    .winner_idx (win_idx),
    .any_vld    (any_vld)
  );

  // The cap only takes over when strictly below every valid request.
  assign use_cap    = !any_vld || (cfg_dt_max < min_dt);
  assign cand       = use_cap ? cfg_dt_max : min_dt;
  assign cand_lim   = use_cap ? '0 : (N_REQ'(1) << win_idx);

  assign time_sum   = SW'(emu_time) + SW'(cand);
  assign time_carry = |time_sum[SW-1:TIME_WIDTH];

  assign step_fire  = (state == RUN);
  // Halt beats a simultaneous start in IDLE.
  assign start_ok   = (state == IDLE) && cmd_start && !cmd_halt;
  assign busy       = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = RUN;
      RUN:  if (cmd_halt || (budget == CNT_WIDTH'(1))) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      budget      <= '0;
      emu_dt      <= '0;
      emu_step_en <= 1'b0;
      emu_limiter <= '0;
      emu_time    <= '0;
      done        <= 1'b0;
      time_ovf    <= 1'b0;
    end else begin
      emu_step_en <= step_fire;
      // FIN lasts one cycle; registering it puts done right after the last step.
      done        <= (state == FIN);

      if (start_ok) begin
        budget <= cmd_steps;
      end else if (step_fire && (budget != '0)) begin
        // A zero budget means free-run and is never counted down.
        budget <= budget - CNT_WIDTH'(1);
      end

      if (step_fire) begin
        emu_dt      <= cand;
        emu_limiter <= cand_lim;
        emu_time    <= time_sum[TIME_WIDTH-1:0];
        if (time_carry) time_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_emu_dt_scheduler.sv
module tb_emu_dt_scheduler;

  logic         clk;
  logic         rst_n;

  // Main DUT (default widths)
  logic [31:0]  cfg_dt_max;
  logic         cmd_start;
  logic [31:0]  cmd_steps;
  logic         cmd_halt;
  logic [127:0] dt_req;
  logic [3:0]   dt_req_vld;
  logic [31:0]  emu_dt;
  logic         emu_step_en;
  logic [3:0]   emu_limiter;
  logic [63:0]  emu_time;
  logic         busy;
  logic         done;
  logic         time_ovf;

  // Narrow-time DUT for the wrap test
  logic [31:0]  s8_dt_max;
  logic         s8_start;
  logic [31:0]  s8_steps;
  logic         s8_halt;
  logic [127:0] s8_req;
  logic [3:0]   s8_vld;
  logic [31:0]  s8_dt;
  logic         s8_step_en;
  logic [3:0]   s8_lim;
  logic [7:0]   s8_time;
  logic         s8_busy;
  logic         s8_done;
  logic         s8_ovf;

  int tests_run;
  int tests_failed;
  logic [63:0] exp_time;

  emu_dt_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_dt_max  (cfg_dt_max),
    .cmd_start   (cmd_start),
    .cmd_steps   (cmd_steps),
    .cmd_halt    (cmd_halt),
    .dt_req      (dt_req),
    .dt_req_vld  (dt_req_vld),
    .emu_dt      (emu_dt),
    .emu_step_en (emu_step_en),
    .emu_limiter (emu_limiter),
    .emu_time    (emu_time),
    .busy        (busy),
    .done        (done),
    .time_ovf    (time_ovf)
  );

  emu_dt_scheduler #(.TIME_WIDTH(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_dt_max  (s8_dt_max),
    .cmd_start   (s8_start),
    .cmd_steps   (s8_steps),
    .cmd_halt    (s8_halt),
    .dt_req      (s8_req),
    .dt_req_vld  (s8_vld),
    .emu_dt      (s8_dt),
    .emu_step_en (s8_step_en),
    .emu_limiter (s8_lim),
    .emu_time    (s8_time),
    .busy        (s8_busy),
    .done        (s8_done),
    .time_ovf    (s8_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] dt_max;
    logic [3:0]  vld;
    logic [31:0] r3, r2, r1, r0;
    logic [31:0] steps;
    logic [31:0] exp_dt;
    logic [3:0]  exp_lim;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Runs one budgeted run with fixed inputs and checks every step, the step
  // count, the done pulse placement and the accumulated time.
  task automatic run_vec(input vec_t v, input int n);
    int   steps_seen;
    int   done_seen;
    logic prev_en;
    bit   finished;
    cfg_dt_max = v.dt_max;
    dt_req_vld = v.vld;
    dt_req     = {v.r3, v.r2, v.r1, v.r0};
    cmd_steps  = v.steps;
    cmd_start  = 1'b1;
    tick();
    cmd_start  = 1'b0;
    chk($sformatf("v%0d_busy", n), {63'd0, busy}, 64'd1);
    steps_seen = 0;
    done_seen  = 0;
    prev_en    = 1'b0;
    finished   = 1'b0;
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      tick();
      if (emu_step_en) begin
        steps_seen++;
        chk($sformatf("v%0d_dt", n), {32'd0, emu_dt}, {32'd0, v.exp_dt});
        chk($sformatf("v%0d_lim", n), {60'd0, emu_limiter}, {60'd0, v.exp_lim});
      end
      if (done) begin
        done_seen++;
        chk($sformatf("v%0d_done_after_step", n), {63'd0, prev_en}, 64'd1);
        finished = 1'b1;
      end
      prev_en = emu_step_en;
    end
    exp_time = exp_time + 64'(v.steps) * 64'(v.exp_dt);
    chk($sformatf("v%0d_steps", n), 64'(steps_seen), 64'(v.steps));
    chk($sformatf("v%0d_done_cnt", n), 64'(done_seen), 64'd1);
    chk($sformatf("v%0d_time", n), emu_time, exp_time);
    tick();
    chk($sformatf("v%0d_hold_dt", n), {32'd0, emu_dt}, {32'd0, v.exp_dt});
    chk($sformatf("v%0d_hold_lim", n), {60'd0, emu_limiter}, {60'd0, v.exp_lim});
    chk($sformatf("v%0d_idle_en", n), {63'd0, emu_step_en}, 64'd0);
  endtask

  initial begin
    int steps_seen;
    int done_seen;
    vec_t rv;

    tests_run    = 0;
    tests_failed = 0;
    exp_time     = 64'd0;

    //                dt_max        vld      r3     r2    r1      r0            steps dt     lim
    vecs[0] = '{32'd1000,       4'b1111, 32'd50, 32'd20, 32'd20, 32'd70,         32'd1, 32'd20,  4'b0010};
    vecs[1] = '{32'd300,        4'b0000, 32'd0,  32'd0,  32'd0,  32'd0,          32'd3, 32'd300, 4'b0000};
    vecs[2] = '{32'd10,         4'b1111, 32'd50, 32'd20, 32'd20, 32'd70,         32'd2, 32'd10,  4'b0000};
    vecs[3] = '{32'd20,         4'b0010, 32'd0,  32'd0,  32'd20, 32'd0,          32'd1, 32'd20,  4'b0010};
    vecs[4] = '{32'd1000,       4'b1000, 32'd7,  32'd1,  32'd1,  32'd1,          32'd2, 32'd7,   4'b1000};
    vecs[5] = '{32'd1000,       4'b1111, 32'd0,  32'd5,  32'd5,  32'd5,          32'd1, 32'd0,   4'b1000};
    vecs[6] = '{32'hFFFF_FFFF,  4'b0011, 32'd0,  32'd0,  32'h10, 32'hFFFF_FFF0,  32'd1, 32'h10,  4'b0010};
    vecs[7] = '{32'd1000,       4'b1110, 32'd9,  32'd9,  32'd9,  32'd3,          32'd2, 32'd9,   4'b0010};

    cfg_dt_max = 32'd1000; cmd_start = 1'b0; cmd_steps = 32'd0; cmd_halt = 1'b0;
    dt_req = '0; dt_req_vld = '0;
    s8_dt_max = 32'd1000; s8_start = 1'b0; s8_steps = 32'd0; s8_halt = 1'b0;
    s8_req = '0; s8_vld = '0;

    rst_n = 1'b0;
    #12;
    chk("rst_dt",   {32'd0, emu_dt}, 64'd0);
    chk("rst_en",   {63'd0, emu_step_en}, 64'd0);
    chk("rst_lim",  {60'd0, emu_limiter}, 64'd0);
    chk("rst_time", emu_time, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ovf",  {63'd0, time_ovf}, 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", {63'd0, busy}, 64'd0);

    // Table-driven selection vectors
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Free-run with halt on the 10th RUN cycle
    cfg_dt_max = 32'd1000; dt_req_vld = 4'b0001; dt_req = {96'd0, 32'd5};
    cmd_steps = 32'd0; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    steps_seen = 0; done_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) cmd_halt = 1'b1;
      tick();
      if (emu_step_en) steps_seen++;
      if (done) done_seen++;
    end
    cmd_halt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (emu_step_en) steps_seen++;
      if (done) done_seen++;
    end
    exp_time = exp_time + 64'd50;
    chk("fr_steps", 64'(steps_seen), 64'd10);
    chk("fr_done",  64'(done_seen), 64'd1);
    chk("fr_busy",  {63'd0, busy}, 64'd0);
    chk("fr_time",  emu_time, exp_time);

    // Start together with halt in IDLE: nothing happens
    cmd_steps = 32'd5; cmd_start = 1'b1; cmd_halt = 1'b1;
    tick();
    cmd_start = 1'b0; cmd_halt = 1'b0;
    chk("sh_busy", {63'd0, busy}, 64'd0);
    steps_seen = 0; done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (emu_step_en) steps_seen++;
      if (done) done_seen++;
    end
    chk("sh_steps", 64'(steps_seen), 64'd0);
    chk("sh_done",  64'(done_seen), 64'd0);

    // Start while running keeps the original budget of 4
    cmd_steps = 32'd4; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    cmd_steps = 32'd100; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    steps_seen = emu_step_en ? 1 : 0; done_seen = 0;
    for (int k = 0; k < 20 && done_seen == 0; k++) begin
      tick();
      if (emu_step_en) steps_seen++;
      if (done) done_seen++;
    end
    exp_time = exp_time + 64'd20;
    chk("rs_steps", 64'(steps_seen), 64'd4);
    chk("rs_done",  64'(done_seen), 64'd1);
    chk("rs_time",  emu_time, exp_time);

    // Async reset between edges after the 4th of 8 steps
    dt_req = {96'd0, 32'd3};
    cmd_steps = 32'd8; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    steps_seen = 0;
    for (int k = 0; k < 20 && steps_seen < 4; k++) begin
      tick();
      if (emu_step_en) steps_seen++;
    end
    chk("ar_pre_steps", 64'(steps_seen), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_dt",   {32'd0, emu_dt}, 64'd0);
    chk("ar_en",   {63'd0, emu_step_en}, 64'd0);
    chk("ar_lim",  {60'd0, emu_limiter}, 64'd0);
    chk("ar_time", emu_time, 64'd0);
    chk("ar_busy", {63'd0, busy}, 64'd0);
    chk("ar_done", {63'd0, done}, 64'd0);
    tick();
    rst_n = 1'b1;
    exp_time = 64'd0;
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) done_seen++;
    end
    chk("ar_no_done", 64'(done_seen), 64'd0);
    rv = '{32'd1000, 4'b0001, 32'd0, 32'd0, 32'd0, 32'd3, 32'd8, 32'd3, 4'b0001};
    run_vec(rv, 8);

    // 8-bit time accumulator: zero step, then wrap
    s8_vld = 4'b0001; s8_steps = 32'd3; s8_start = 1'b1;
    tick();
    s8_start = 1'b0;
    s8_req = {96'd0, 32'd0};
    tick();
    chk("ov_en0",   {63'd0, s8_step_en}, 64'd1);
    chk("ov_time0", {56'd0, s8_time}, 64'd0);
    chk("ov_ovf0",  {63'd0, s8_ovf}, 64'd0);
    s8_req = {96'd0, 32'd200};
    tick();
    chk("ov_time1", {56'd0, s8_time}, 64'd200);
    chk("ov_ovf1",  {63'd0, s8_ovf}, 64'd0);
    s8_req = {96'd0, 32'd100};
    tick();
    chk("ov_time2", {56'd0, s8_time}, 64'd44);
    chk("ov_ovf2",  {63'd0, s8_ovf}, 64'd1);
    tick();
    chk("ov_done",  {63'd0, s8_done}, 64'd1);
    tick();
    tick();
    chk("ov_hold",  {63'd0, s8_ovf}, 64'd1);
    chk("ov_time_hold", {56'd0, s8_time}, 64'd44);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
